// File: rtl/axis_pps_averager_pkg.sv
// Shared types and default sizing for the PPS averaging stage.
// Consumers may override the widths; these are the defaults the block is built around.
package axis_pps_averager_pkg;

    typedef enum logic {
        ACQ    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEF_CNTR_WIDTH = 32;
    localparam int DEF_LOG2_AVG   = 3;
    localparam int N              = 1 << DEF_LOG2_AVG;
    localparam int ACC_WIDTH      = DEF_CNTR_WIDTH + DEF_LOG2_AVG;

endpackage

// File: rtl/axis_pps_averager_sat_counter.sv
// Saturating event counter used for the status register fields.
// Holds at all-ones instead of wrapping so software never sees a small count after a flood.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axis_pps_averager.sv
// Windows, averages and lock-tracks per-second clock counts from the PPS counter.
// Emits the sum of 2^LOG2_AVG accepted samples on a handshaked AXIS master.
module axis_pps_averager
    import axis_pps_averager_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH         = DEF_CNTR_WIDTH,
    parameter int LOG2_AVG           = DEF_LOG2_AVG,
    parameter int M_AXIS_TDATA_WIDTH = 64,
    parameter int STS_WIDTH          = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [CNTR_WIDTH-1:0]         cfg_nominal,
    input  logic [CNTR_WIDTH-1:0]         cfg_tolerance,
    input  logic [31:0]                   cfg_timeout,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          sts_locked,
    output logic [STS_WIDTH-1:0]          sts_rejected,
    output logic [STS_WIDTH-1:0]          sts_timeouts,
    output logic [STS_WIDTH-1:0]          sts_overruns
);

    localparam int ACC_W = CNTR_WIDTH + LOG2_AVG;

    state_t                  state, state_nxt;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;
    logic [LOG2_AVG-1:0]     cnt;
    logic [31:0]             tcnt;
    logic [CNTR_WIDTH-1:0]   sample;
    logic signed [CNTR_WIDTH:0] diff;
    logic [CNTR_WIDTH:0]     abs_diff;
    logic                    in_window;
    logic                    accept;
    logic                    reject;
    logic                    emit;
    logic                    timeout_fire;
    logic                    handshake;
    logic                    overrun;

    // One extra bit keeps the difference exact when nominal sits below the tolerance.
    assign sample       = s_axis_tdata[CNTR_WIDTH-1:0];
    assign diff         = $signed({1'b0, sample}) - $signed({1'b0, cfg_nominal});
    assign abs_diff     = diff[CNTR_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign in_window    = abs_diff <= {1'b0, cfg_tolerance};

    assign accept       = s_axis_tvalid & in_window;
    assign reject       = s_axis_tvalid & ~in_window;
    assign emit         = accept & (&cnt);
    assign acc_sum      = acc + ACC_W'(sample);
    assign timeout_fire = (cfg_timeout != 32'd0) & ~s_axis_tvalid
                        & (tcnt == cfg_timeout - 32'd1);
    assign handshake    = m_axis_tvalid & m_axis_tready;
    assign overrun      = emit & m_axis_tvalid & ~m_axis_tready;
    assign sts_locked   = (state == LOCKED);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ACQ;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first means every path drives state_nxt, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ACQ:     if (emit) state_nxt = LOCKED;
            LOCKED:  if (reject || timeout_fire) state_nxt = ACQ;
            default: state_nxt = ACQ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc           <= '0;
            cnt           <= '0;
            tcnt          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (s_axis_tvalid || timeout_fire) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 32'd1;
            end

            if (reject || timeout_fire || emit) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end

            // A fresh sum always wins over a same-cycle handshake so tvalid stays high.
            if (emit) begin
                m_axis_tdata  <= M_AXIS_TDATA_WIDTH'(acc_sum);
                m_axis_tvalid <= 1'b1;
            end else if (handshake) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(STS_WIDTH)) u_rejected (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (reject),
        .count   (sts_rejected)
    );

    sat_counter #(.WIDTH(STS_WIDTH)) u_timeouts (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (timeout_fire),
        .count   (sts_timeouts)
    );

    sat_counter #(.WIDTH(STS_WIDTH)) u_overruns (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (overrun),
        .count   (sts_overruns)
    );

endmodule

// File: tb/tb_axis_pps_averager.sv
// Scoreboard bench for axis_pps_averager: directed scenarios then randomized traffic.
// A queue-based reference model predicts sums and status; a negedge monitor checks transfers.
module tb_axis_pps_averager;
    import axis_pps_averager_pkg::*;

    localparam int STS_W   = 4;
    localparam int STS_MAX = (1 << STS_W) - 1;

    logic              aclk;
    logic              aresetn;
    logic [31:0]       cfg_nominal;
    logic [31:0]       cfg_tolerance;
    logic [31:0]       cfg_timeout;
    logic [31:0]       s_axis_tdata;
    logic              s_axis_tvalid;
    logic [63:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              sts_locked;
    logic [STS_W-1:0]  sts_rejected;
    logic [STS_W-1:0]  sts_timeouts;
    logic [STS_W-1:0]  sts_overruns;

    axis_pps_averager #(
        .S_AXIS_TDATA_WIDTH (32),
        .CNTR_WIDTH         (DEF_CNTR_WIDTH),
        .LOG2_AVG           (DEF_LOG2_AVG),
        .M_AXIS_TDATA_WIDTH (64),
        .STS_WIDTH          (STS_W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_nominal   (cfg_nominal),
        .cfg_tolerance (cfg_tolerance),
        .cfg_timeout   (cfg_timeout),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .sts_locked    (sts_locked),
        .sts_rejected  (sts_rejected),
        .sts_timeouts  (sts_timeouts),
        .sts_overruns  (sts_overruns)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] acc_q[$];
    int          exp_rej;
    int          exp_tmo;
    int          exp_ovr;
    bit          exp_locked;
    int          idle;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int x);
        return (x < STS_MAX) ? x + 1 : x;
    endfunction

    function automatic bit in_window(input logic [31:0] s);
        longint d;
        d = longint'(s) - longint'(cfg_nominal);
        if (d < 0) d = -d;
        return d <= longint'(cfg_tolerance);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        acc_q.delete();
        exp_rej    = 0;
        exp_tmo    = 0;
        exp_ovr    = 0;
        exp_locked = 0;
        idle       = 0;
    endtask

    // Behavioural view: collect accepted samples; every N of them forms one sum.
    task automatic model_step(input logic v, input logic [31:0] d, input logic rdy);
        logic [63:0] sum;
        if (v) begin
            idle = 0;
            if (in_window(d)) begin
                acc_q.push_back(d);
                if (acc_q.size() == N) begin
                    sum = 0;
                    foreach (acc_q[i]) sum += 64'(acc_q[i]);
                    acc_q.delete();
                    if (exp_q.size() != 0 && !rdy) begin
                        void'(exp_q.pop_back());
                        exp_ovr = sat_inc(exp_ovr);
                    end
                    exp_q.push_back(sum);
                    exp_locked = 1;
                end
            end else begin
                acc_q.delete();
                exp_rej    = sat_inc(exp_rej);
                exp_locked = 0;
            end
        end else begin
            idle++;
            if (cfg_timeout != 0 && idle == int'(cfg_timeout)) begin
                acc_q.delete();
                exp_tmo    = sat_inc(exp_tmo);
                exp_locked = 0;
                idle       = 0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic rdy);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        model_step(v, d, rdy);
        @(posedge aclk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [31:0] d, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, d, rdy);
    endtask

    task automatic idle_n(input int n, input bit rand_rdy);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 32'd0, rand_rdy ? ($urandom_range(0, 9) < 3) : 1'b1);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_locked"},   64'(sts_locked),   64'(exp_locked));
        check({tag, "_rejected"}, 64'(sts_rejected), 64'(exp_rej));
        check({tag, "_timeouts"}, 64'(sts_timeouts), 64'(exp_tmo));
        check({tag, "_overruns"}, 64'(sts_overruns), 64'(exp_ovr));
    endtask

    task automatic do_reset(input string tag);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_tdata"},  m_axis_tdata,       64'd0);
        check_status(tag);
        aresetn = 1'b1;
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got sum %0d expected no transfer", m_axis_tdata);
            end else begin
                check("sum", m_axis_tdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        cfg_nominal   = 32'd124999999;
        cfg_tolerance = 32'd1000;
        cfg_timeout   = 32'd0;
        do_reset("reset");

        // Lock and average.
        send_n(7, 32'd124999999, 1'b1);
        check("tvalid_before_8th", 64'(m_axis_tvalid), 64'd0);
        cycle(1'b1, 32'd124999999, 1'b1);
        check("tvalid_after_8th", 64'(m_axis_tvalid), 64'd1);
        check("tdata_after_8th",  m_axis_tdata,       64'd999999992);
        check("locked_after_8th", 64'(sts_locked),    64'd1);
        cycle(1'b0, 32'd0, 1'b1);
        check("tvalid_consumed", 64'(m_axis_tvalid), 64'd0);

        // Rejection restarts the average.
        send_n(3, 32'd124999999, 1'b1);
        cycle(1'b1, 32'd125001000, 1'b1);
        check("reject_no_output", 64'(m_axis_tvalid), 64'd0);
        check_status("reject");
        send_n(8, 32'd125000000, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        check_status("relock");

        // Window edges, including a nominal below the tolerance.
        cycle(1'b1, 32'd125000999, 1'b1); check_status("edge_hi_in");
        cycle(1'b1, 32'd125001000, 1'b1); check_status("edge_hi_out");
        cycle(1'b1, 32'd124998999, 1'b1); check_status("edge_lo_in");
        cycle(1'b1, 32'd124998998, 1'b1); check_status("edge_lo_out");
        cfg_nominal   = 32'd5;
        cfg_tolerance = 32'd10;
        cycle(1'b1, 32'd0,          1'b1); check_status("small_zero");
        cycle(1'b1, 32'hFFFF_FFFC,  1'b1); check_status("small_wrap");
        cycle(1'b1, 32'd15,         1'b1); check_status("small_15");
        cycle(1'b1, 32'd16,         1'b1); check_status("small_16");
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i), 1'b1);
        idle_n(2, 1'b0);
        check_status("small_sum");
        cfg_nominal   = 32'd124999999;
        cfg_tolerance = 32'd1000;

        // Backpressure: second sum overwrites the pending one.
        send_n(16, 32'd124999999, 1'b0);
        check_status("bp");
        check("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("bp_tdata",  m_axis_tdata,       64'd999999992);
        cycle(1'b0, 32'd0, 1'b1);
        check("bp_drained", 64'(m_axis_tvalid), 64'd0);

        // Timeout fires after exactly cfg_timeout idle clocks.
        cfg_timeout = 32'd200;
        send_n(8, 32'd124999999, 1'b1);
        idle_n(199, 1'b0);
        check_status("tmo_199");
        idle_n(1, 1'b0);
        check_status("tmo_200");
        send_n(8, 32'd124999999, 1'b1);
        idle_n(199, 1'b0);
        cycle(1'b1, 32'd124999999, 1'b1);
        check_status("tmo_saved");

        // Reset mid-accumulation discards the partial sum.
        send_n(5, 32'd125000500, 1'b1);
        do_reset("midreset");
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'd124999999 + 32'(i * 100) - 32'd300, 1'b1);
        idle_n(2, 1'b0);
        check_status("after_reset");

        // Randomized traffic with idle bursts and random backpressure.
        cfg_timeout = 32'd40;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                idle_n($urandom_range(30, 60), 1'b1);
            end else begin
                logic [31:0] off;
                logic [31:0] d;
                off = 32'($urandom_range(0, 1100));
                d   = $urandom_range(0, 1) ? cfg_nominal + off : cfg_nominal - off;
                cycle($urandom_range(0, 3) == 0, d, $urandom_range(0, 9) < 3);
            end
            if (c % 100 == 99) check_status("rand");
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 32'd0, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_status("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
